// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle between the FP ALU operand registers,
// the pipelined adder and the result writeback.
interface fp_addsub_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic [2:0]   r_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         overflow;
   logic         underflow;
   logic         invalid;
   logic         inexact;

   modport slave (
      input  in_valid, op_a, op_b, sub, r_mode, out_ready,
      output in_ready, out_valid, result, overflow, underflow, invalid, inexact
   );

   modport master (
      output in_valid, op_a, op_b, sub, r_mode, out_ready,
      input  in_ready, out_valid, result, overflow, underflow, invalid, inexact
   );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE 754 adder/subtractor: align, add+normalise, round+pack.
// One global advance signal stalls every stage together under backpressure.
module fp_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic              clk,
   input logic              rst_n,
   fp_addsub_pipe_if.slave  io
);
   localparam int W      = 1 + EXP_W + MAN_W;
   localparam int SW     = MAN_W + 4;   // hidden + fraction + guard/round/sticky
   localparam int XW     = EXP_W + 2;
   localparam int STAGES = 2;

   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100
   } rmode_e;

   typedef struct packed {
      logic           sign;
      logic           eff_sub;
      logic [XW-1:0]  exp;
      logic [SW-1:0]  sig_big;
      logic [SW-1:0]  sig_sml;
      logic           spec;
      logic           spec_inv;
      logic [W-1:0]   spec_word;
      rmode_e         rm;
   } s1_t;

   typedef struct packed {
      logic           sign;
      logic           eff_sub;
      logic [XW-1:0]  exp;
      logic [SW-1:0]  mant;
      logic           zero;
      logic           spec;
      logic           spec_inv;
      logic [W-1:0]   spec_word;
      rmode_e         rm;
   } s2_t;

   logic [STAGES:0] vld_pipe;
   logic            adv;
   s1_t             s1_d, s1_q;
   s2_t             s2_d, s2_q;
   logic [W-1:0]    res_d, res_q;
   logic [3:0]      flg_d, flg_q;   // {overflow, underflow, invalid, inexact}

   assign adv          = !vld_pipe[STAGES] || io.out_ready;
   assign io.in_ready  = adv && rst_n;
   assign io.out_valid = vld_pipe[STAGES];
   assign io.result    = res_q;
   assign {io.overflow, io.underflow, io.invalid, io.inexact} = flg_q;

   // ---------------- S1: unpack, classify, swap, align ----------------
   logic             sa, sb, a_max, b_max, a_inf, b_inf, a_nan, b_nan, swap, sticky;
   logic [EXP_W-1:0] ea, eb, xa, xb, xbig, xsml;
   logic [MAN_W-1:0] fa, fb;
   logic [MAN_W:0]   ma, mb, mbig, msml;
   logic [SW-1:0]    ext, mask;
   logic [31:0]      d32, sh;

   always_comb begin
      sa    = io.op_a[W-1];
      sb    = io.op_b[W-1] ^ io.sub;
      ea    = io.op_a[W-2:MAN_W];
      eb    = io.op_b[W-2:MAN_W];
      fa    = io.op_a[MAN_W-1:0];
      fb    = io.op_b[MAN_W-1:0];
      a_max = (ea == EXP_ONES);
      b_max = (eb == EXP_ONES);
      a_inf = a_max && (fa == '0);
      b_inf = b_max && (fb == '0);
      a_nan = a_max && (fa != '0);
      b_nan = b_max && (fb != '0);
      // subnormals sit at exponent 1 with a clear hidden bit
      xa    = (ea == '0) ? EXP_W'(1) : ea;
      xb    = (eb == '0) ? EXP_W'(1) : eb;
      ma    = {ea != '0, fa};
      mb    = {eb != '0, fb};
      swap  = {xb, mb} > {xa, ma};
      xbig  = swap ? xb : xa;
      xsml  = swap ? xa : xb;
      mbig  = swap ? mb : ma;
      msml  = swap ? ma : mb;
      d32   = 32'(xbig - xsml);
      sh    = (d32 > 32'(SW-1)) ? 32'(SW-1) : d32;
      ext   = {msml, 3'b000};
      mask  = ~({SW{1'b1}} << sh);
      sticky = |(ext & mask);

      s1_d           = '0;
      s1_d.sign      = swap ? sb : sa;
      s1_d.eff_sub   = sa ^ sb;
      s1_d.exp       = XW'(xbig);
      s1_d.sig_big   = {mbig, 3'b000};
      s1_d.sig_sml   = (ext >> sh) | {{(SW-1){1'b0}}, sticky};
      s1_d.spec      = a_max || b_max;
      s1_d.spec_inv  = (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]) ||
                       (a_inf && b_inf && (sa != sb));
      s1_d.spec_word = (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) ? QNAN :
                       {a_inf ? sa : sb, EXP_ONES, {MAN_W{1'b0}}};
      s1_d.rm        = (io.r_mode > 3'd4) ? RNE : rmode_e'(io.r_mode);
   end

   // ---------------- S2: add/subtract and normalise ----------------
   logic [SW:0] sum;
   logic [31:0] lz, lim, shl;

   always_comb begin
      sum = s1_q.eff_sub ? ({1'b0, s1_q.sig_big} - {1'b0, s1_q.sig_sml})
                         : ({1'b0, s1_q.sig_big} + {1'b0, s1_q.sig_sml});
      lz = 32'(SW);
      for (int i = 0; i < SW; i++)
         if (sum[i]) lz = 32'(SW - 1 - i);
      // never normalise below exponent 1: the remainder stays subnormal
      lim = 32'(s1_q.exp) - 32'd1;
      shl = (lz < lim) ? lz : lim;

      s2_d           = '0;
      s2_d.sign      = s1_q.sign;
      s2_d.eff_sub   = s1_q.eff_sub;
      s2_d.zero      = (sum == '0);
      s2_d.spec      = s1_q.spec;
      s2_d.spec_inv  = s1_q.spec_inv;
      s2_d.spec_word = s1_q.spec_word;
      s2_d.rm        = s1_q.rm;
      if (sum[SW]) begin
         s2_d.mant = {sum[SW:2], sum[1] | sum[0]};
         s2_d.exp  = s1_q.exp + XW'(1);
      end else begin
         s2_d.mant = sum[SW-1:0] << shl;
         s2_d.exp  = s1_q.exp - XW'(shl);
      end
   end

   // ---------------- S3: round, pack, flags ----------------
   logic               grs, up, tiny, ovf;
   logic [MAN_W+1:0]   rnd;
   logic [XW-1:0]      ex;
   logic [MAN_W-1:0]   fr;

   always_comb begin
      grs = |s2_q.mant[2:0];
      unique case (s2_q.rm)
         RTZ:     up = 1'b0;
         RDN:     up = s2_q.sign && grs;
         RUP:     up = !s2_q.sign && grs;
         RMM:     up = s2_q.mant[2];
         default: up = s2_q.mant[2] && (s2_q.mant[1] || s2_q.mant[0] || s2_q.mant[3]);
      endcase
      rnd  = {1'b0, s2_q.mant[SW-1:3]} + (MAN_W+2)'(up);
      tiny = !s2_q.mant[SW-1];
      if (rnd[MAN_W+1]) begin
         ex = s2_q.exp + XW'(1);
         fr = rnd[MAN_W:1];
      end else begin
         ex = rnd[MAN_W] ? s2_q.exp : '0;
         fr = rnd[MAN_W-1:0];
      end
      ovf = (ex >= XW'(EXP_ONES));

      res_d = {s2_q.sign, ex[EXP_W-1:0], fr};
      flg_d = {1'b0, tiny && grs, 1'b0, grs};
      if (s2_q.spec) begin
         res_d = s2_q.spec_word;
         flg_d = {2'b00, s2_q.spec_inv, 1'b0};
      end else if (s2_q.zero) begin
         res_d = {s2_q.eff_sub ? (s2_q.rm == RDN) : s2_q.sign, {(W-1){1'b0}}};
         flg_d = '0;
      end else if (ovf) begin
         flg_d = 4'b1001;
         if ((s2_q.rm == RTZ) || (s2_q.rm == RDN && !s2_q.sign) || (s2_q.rm == RUP && s2_q.sign))
            res_d = {s2_q.sign, EXP_MAXF, {MAN_W{1'b1}}};
         else
            res_d = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         res_q    <= '0;
         flg_q    <= '0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[STAGES-1:0], io.in_valid};
         // output word only changes when a real result arrives
         if (vld_pipe[STAGES-1]) begin
            res_q <= res_d;
            flg_q <= flg_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe (binary32): table of single ops,
// then a stalled stream and a mid-stream reset.
module tb_fp_addsub_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [2:0]  rm;
      logic [31:0] res;
      logic [3:0]  flg;   // {overflow, underflow, invalid, inexact}
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {bus.overflow, bus.underflow, bus.invalid, bus.inexact};
   endfunction

   task automatic drive(input vec_t v);
      bus.op_a   = v.a;
      bus.op_b   = v.b;
      bus.sub    = v.sub;
      bus.r_mode = v.rm;
   endtask

   task automatic run_one(input int i);
      int cnt;
      @(negedge clk);
      bus.in_valid = 1'b1;
      drive(vecs[i]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      cnt = 1;
      while (!bus.out_valid && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      chk($sformatf("vec%0d.latency", i), cnt, 3);
      chk($sformatf("vec%0d.result", i), bus.result, vecs[i].res);
      chk($sformatf("vec%0d.flags", i), 32'(flags()), 32'(vecs[i].flg));
   endtask

   initial begin
      int          sent, got, cyc;
      logic        held;
      logic [31:0] held_res;

      vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 4'h0};
      vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 4'h0};
      vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 4'h0};
      vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 4'h9};
      vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 4'h9};
      vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 3'd0, 32'h7FC00000, 4'h2};
      vecs[6]  = '{32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 4'h2};
      vecs[7]  = '{32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 32'h7F800000, 4'h0};
      vecs[8]  = '{32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000002, 4'h0};
      vecs[9]  = '{32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 4'h1};
      vecs[10] = '{32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 4'h1};
      vecs[11] = '{32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 4'h1};
      vecs[12] = '{32'h3F800000, 32'h33800000, 1'b0, 3'd7, 32'h3F800000, 4'h1};
      vecs[13] = '{32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 4'h0};
      vecs[14] = '{32'h00000000, 32'h80000000, 1'b0, 3'd0, 32'h00000000, 4'h0};
      vecs[15] = '{32'h00000000, 32'h80000000, 1'b0, 3'd2, 32'h80000000, 4'h0};
      vecs[16] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd2, 32'h7F7FFFFF, 4'h9};
      vecs[17] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 32'hFF7FFFFF, 4'h9};
      vecs[18] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd2, 32'hFF800000, 4'h9};
      vecs[19] = '{32'h3F800000, 32'h33800000, 1'b1, 3'd0, 32'h3F7FFFFF, 4'h0};
      vecs[20] = '{32'h3F800001, 32'h33800000, 1'b0, 3'd0, 32'h3F800002, 4'h1};
      vecs[21] = '{32'h40000000, 32'h40400000, 1'b1, 3'd0, 32'hBF800000, 4'h0};
      vecs[22] = '{32'h7FC00000, 32'hFF800000, 1'b0, 3'd0, 32'h7FC00000, 4'h0};
      vecs[23] = '{32'hFF800000, 32'h3F800000, 1'b0, 3'd0, 32'hFF800000, 4'h0};
      vecs[24] = '{32'h00400000, 32'h00400000, 1'b0, 3'd0, 32'h00800000, 4'h0};
      vecs[25] = '{32'hBF800000, 32'hB3800000, 1'b0, 3'd3, 32'hBF800000, 4'h1};
      vecs[26] = '{32'hBF800000, 32'hB3800000, 1'b0, 3'd2, 32'hBF800001, 4'h1};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(vecs[0]);

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst.out_valid", 32'(bus.out_valid), 0);
      chk("rst.in_ready", 32'(bus.in_ready), 0);
      chk("rst.result", bus.result, 0);
      chk("rst.flags", 32'(flags()), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel.in_ready", 32'(bus.in_ready), 1);

      for (int i = 0; i < NV; i++) run_one(i);

      // stream 8 ops, consumer stalls in cycles 4..6
      sent = 0; got = 0; cyc = 0; held = 1'b0; held_res = '0;
      while (got < 8 && cyc < 60) begin
         @(negedge clk);
         bus.out_ready = !(cyc >= 4 && cyc <= 6);
         bus.in_valid  = (sent < 8);
         if (sent < 8) drive(vecs[sent]);
         #1;
         chk($sformatf("stream.c%0d.in_ready", cyc), 32'(bus.in_ready),
             32'(!bus.out_valid || bus.out_ready));
         if (bus.out_valid) begin
            if (held) chk($sformatf("stream.c%0d.hold", cyc), bus.result, held_res);
            if (bus.out_ready) begin
               chk($sformatf("stream.r%0d.result", got), bus.result, vecs[got].res);
               chk($sformatf("stream.r%0d.flags", got), 32'(flags()), 32'(vecs[got].flg));
               got++;
               held = 1'b0;
            end else begin
               held     = 1'b1;
               held_res = bus.result;
            end
         end
         if (bus.in_valid && bus.in_ready) sent++;
         cyc++;
      end
      chk("stream.count", got, 8);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // reset pulse mid-stream discards in-flight ops
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         drive(vecs[c + 9]);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("mid.pre_valid", 32'(bus.out_valid), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid.out_valid", 32'(bus.out_valid), 0);
      chk("mid.in_ready", 32'(bus.in_ready), 0);
      chk("mid.result", bus.result, 0);
      chk("mid.flags", 32'(flags()), 0);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("mid.nostale%0d", c), 32'(bus.out_valid), 0);
      end
      run_one(21);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
